// File: rtl/elastic_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe_if
// Brief    : Handshake, flush and status bundle for elastic_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface elastic_pipe_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 2)
);
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] InData;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] OutData;
   logic             Flush;
   logic [CW-1:0]    Occupancy;
   logic [DEPTH-1:0] StageValid;

   modport master (
      output InValid, InData, OutReady, Flush,
      input  InReady, OutValid, OutData, Occupancy, StageValid
   );

   modport slave (
      input  InValid, InData, OutReady, Flush,
      output InReady, OutValid, OutData, Occupancy, StageValid
   );
endinterface
`default_nettype wire

// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : elastic_pipe
// Brief    : Elastic register chain with per-stage valid, valid/ready at both
//            ends, bubble collapse and synchronous flush.
//            Optional input skid buffer: ELASTIC_PIPE_SKID_BUF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module elastic_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 3,
   parameter int CW    = $clog2(DEPTH + 2)
) (
   input  wire logic     clk,
   input  wire logic     Reset,
   elastic_pipe_if.slave bus
);

   logic [DEPTH-1:0] stage_v_q;
   logic [DEPTH-1:0] stage_v_d;
   logic [WIDTH-1:0] stage_d_q [DEPTH];
   logic [WIDTH-1:0] stage_d_d [DEPTH];
   logic [CW-1:0]    occ_q;
   logic [CW-1:0]    occ_d;

   logic [DEPTH-1:0] w_rdy;
   logic [DEPTH-1:0] w_src_v;
   logic [WIDTH-1:0] w_src_d [DEPTH];
   logic             w_src0_v;
   logic [WIDTH-1:0] w_src0_d;
   logic [CW-1:0]    w_skid_cnt;

   // Ready ripples from the output back to the input so any bubble lets upstream advance.
   always_comb begin
      logic r;
      w_rdy = '0;
      r = ~stage_v_q[DEPTH-1] | bus.OutReady;
      w_rdy[DEPTH-1] = r;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         r = ~stage_v_q[i] | r;
         w_rdy[i] = r;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign w_src_v[gi] = w_src0_v;
            assign w_src_d[gi] = w_src0_d;
         end else begin : g_body
            assign w_src_v[gi] = stage_v_q[gi-1];
            assign w_src_d[gi] = stage_d_q[gi-1];
         end
      end
   endgenerate

   // Data only loads with a valid beat so OutData keeps its last value while idle.
   always_comb begin
      stage_v_d = stage_v_q;
      stage_d_d = stage_d_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_rdy[i]) begin
            stage_v_d[i] = w_src_v[i];
            if (w_src_v[i]) begin
               stage_d_d[i] = w_src_d[i];
            end
         end
      end
      if (bus.Flush) begin
         stage_v_d = '0;
      end
   end

`ifdef ELASTIC_PIPE_SKID_BUF_EN
   logic             skid_v_q;
   logic             skid_v_d;
   logic [WIDTH-1:0] skid_d_q;
   logic [WIDTH-1:0] skid_d_d;
   logic             w_in_xfer;

   assign bus.InReady = ~skid_v_q;
   assign w_in_xfer   = bus.InValid & ~skid_v_q;
   // A held skid beat always goes ahead of new input to keep FIFO order.
   assign w_src0_v    = skid_v_q | w_in_xfer;
   assign w_src0_d    = skid_v_q ? skid_d_q : bus.InData;
   assign w_skid_cnt  = CW'(skid_v_d);

   always_comb begin
      skid_v_d = skid_v_q;
      skid_d_d = skid_d_q;
      if (skid_v_q && w_rdy[0]) begin
         skid_v_d = 1'b0;
      end else if (w_in_xfer && !w_rdy[0]) begin
         skid_v_d = 1'b1;
         skid_d_d = bus.InData;
      end
      if (bus.Flush) begin
         skid_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         skid_v_q <= 1'b0;
         skid_d_q <= '0;
      end else begin
         skid_v_q <= skid_v_d;
         skid_d_q <= skid_d_d;
      end
   end
`else
   assign bus.InReady = w_rdy[0];
   assign w_src0_v    = bus.InValid & w_rdy[0];
   assign w_src0_d    = bus.InData;
   assign w_skid_cnt  = '0;
`endif

   always_comb begin
      occ_d = w_skid_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         occ_d = occ_d + CW'(stage_v_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         stage_v_q <= '0;
         occ_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stage_d_q[i] <= '0;
         end
      end else begin
         stage_v_q <= stage_v_d;
         occ_q     <= occ_d;
         stage_d_q <= stage_d_d;
      end
   end

   assign bus.OutValid   = stage_v_q[DEPTH-1];
   assign bus.OutData    = stage_d_q[DEPTH-1];
   assign bus.Occupancy  = occ_q;
   assign bus.StageValid = stage_v_q;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_elastic_pipe
// Brief    : Directed self-checking bench for elastic_pipe (DEPTH=3, WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe;
   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 2);

   logic clk = 1'b0;
   logic Reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   elastic_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

   elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; bus.InValid = 1'b0; bus.InData = '0; bus.OutReady = 1'b0; bus.Flush = 1'b0;
      step(); step();
      Reset = 1'b0;
      bus.InValid = 1'b1; bus.InData = 8'hC1; step();
      bus.InData = 8'hC2; step();
      bus.InValid = 1'b0;
      n_tests++; if (bus.Occupancy !== 3'd2) begin n_fail++; $display("FAIL rst_pre_occ: got %0d expected 2", bus.Occupancy); end
      n_tests++; if (bus.StageValid !== 3'b011) begin n_fail++; $display("FAIL rst_pre_sv: got %b expected 011", bus.StageValid); end
      Reset = 1'b1; step(); step();
      Reset = 1'b0; #1;
      n_tests++; if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %b expected 0", bus.OutValid); end
      n_tests++; if (bus.StageValid !== 3'b000) begin n_fail++; $display("FAIL rst_sv: got %b expected 000", bus.StageValid); end
      n_tests++; if (bus.Occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", bus.Occupancy); end
      n_tests++; if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL rst_ir: got %b expected 1", bus.InReady); end
      n_tests++; if (bus.OutData !== 8'h00) begin n_fail++; $display("FAIL rst_od: got %h expected 00", bus.OutData); end
   endtask

   task automatic test_latency();
      logic [7:0] din [3];
      logic       exp_ov [6];
      logic [7:0] exp_od [6];
      logic [2:0] exp_occ [6];
      din     = '{8'h11, 8'h22, 8'h33};
      exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_od  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      exp_occ = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
      bus.OutReady = 1'b1;
      for (int k = 0; k < 6; k++) begin
         bus.InValid = (k < 3);
         if (k < 3) bus.InData = din[k];
         step();
         n_tests++; if (bus.OutValid !== exp_ov[k]) begin n_fail++; $display("FAIL lat_ov[%0d]: got %b expected %b", k, bus.OutValid, exp_ov[k]); end
         n_tests++; if (bus.Occupancy !== exp_occ[k]) begin n_fail++; $display("FAIL lat_occ[%0d]: got %0d expected %0d", k, bus.Occupancy, exp_occ[k]); end
         if (exp_ov[k]) begin
            n_tests++; if (bus.OutData !== exp_od[k]) begin n_fail++; $display("FAIL lat_od[%0d]: got %h expected %h", k, bus.OutData, exp_od[k]); end
         end
      end
      bus.InValid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_od [4];
      exp_od = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      bus.OutReady = 1'b0; bus.InValid = 1'b1;
      bus.InData = 8'hA1; step();
      bus.InData = 8'hA2; step();
      bus.InData = 8'hA3; step();
      bus.InData = 8'hA4; #1;
      n_tests++; if (bus.InReady !== 1'b0) begin n_fail++; $display("FAIL bp_full_ir: got %b expected 0", bus.InReady); end
      n_tests++; if (bus.Occupancy !== 3'd3) begin n_fail++; $display("FAIL bp_full_occ: got %0d expected 3", bus.Occupancy); end
      n_tests++; if (bus.StageValid !== 3'b111) begin n_fail++; $display("FAIL bp_full_sv: got %b expected 111", bus.StageValid); end
      step();
      n_tests++; if (bus.OutData !== 8'hA1 || bus.Occupancy !== 3'd3) begin n_fail++; $display("FAIL bp_hold: got od=%h occ=%0d expected od=a1 occ=3", bus.OutData, bus.Occupancy); end
      bus.OutReady = 1'b1; #1;
      n_tests++; if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL bp_passthru_ir: got %b expected 1", bus.InReady); end
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (bus.OutValid !== 1'b1 || bus.OutData !== exp_od[k]) begin n_fail++; $display("FAIL bp_out[%0d]: got ov=%b od=%h expected ov=1 od=%h", k, bus.OutValid, bus.OutData, exp_od[k]); end
         step();
         bus.InValid = 1'b0;
      end
      n_tests++; if (bus.OutValid !== 1'b0 || bus.Occupancy !== 3'd0) begin n_fail++; $display("FAIL bp_drained: got ov=%b occ=%0d expected ov=0 occ=0", bus.OutValid, bus.Occupancy); end
   endtask

   task automatic test_bubble();
      bus.OutReady = 1'b0; bus.InValid = 1'b1; bus.InData = 8'h44; step();
      bus.InValid = 1'b0; step(); step();
      n_tests++; if (bus.StageValid !== 3'b100) begin n_fail++; $display("FAIL bub_sv0: got %b expected 100", bus.StageValid); end
      bus.InValid = 1'b1; bus.InData = 8'h55; #1;
      n_tests++; if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL bub_ir: got %b expected 1", bus.InReady); end
      step();
      bus.InValid = 1'b0;
      n_tests++; if (bus.StageValid !== 3'b101) begin n_fail++; $display("FAIL bub_sv1: got %b expected 101", bus.StageValid); end
      step();
      n_tests++; if (bus.StageValid !== 3'b110) begin n_fail++; $display("FAIL bub_sv2: got %b expected 110", bus.StageValid); end
      bus.OutReady = 1'b1; #1;
      n_tests++; if (bus.OutValid !== 1'b1 || bus.OutData !== 8'h44) begin n_fail++; $display("FAIL bub_out0: got ov=%b od=%h expected ov=1 od=44", bus.OutValid, bus.OutData); end
      step();
      n_tests++; if (bus.OutValid !== 1'b1 || bus.OutData !== 8'h55) begin n_fail++; $display("FAIL bub_out1: got ov=%b od=%h expected ov=1 od=55", bus.OutValid, bus.OutData); end
      step();
      n_tests++; if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL bub_empty: got %b expected 0", bus.OutValid); end
   endtask

   task automatic test_flush();
      bus.OutReady = 1'b0; bus.InValid = 1'b1;
      bus.InData = 8'h66; step();
      bus.InData = 8'h67; step();
      n_tests++; if (bus.Occupancy !== 3'd2 || bus.StageValid !== 3'b011) begin n_fail++; $display("FAIL fl_pre: got occ=%0d sv=%b expected occ=2 sv=011", bus.Occupancy, bus.StageValid); end
      bus.Flush = 1'b1; bus.InData = 8'h77; bus.OutReady = 1'b1; #1;
      n_tests++; if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL fl_ir: got %b expected 1", bus.InReady); end
      step();
      bus.Flush = 1'b0; bus.InValid = 1'b0;
      n_tests++; if (bus.StageValid !== 3'b000) begin n_fail++; $display("FAIL fl_sv: got %b expected 000", bus.StageValid); end
      n_tests++; if (bus.Occupancy !== 3'd0) begin n_fail++; $display("FAIL fl_occ: got %0d expected 0", bus.Occupancy); end
      for (int k = 0; k < 5; k++) begin
         n_tests++; if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL fl_leak[%0d]: got ov=%b od=%h expected ov=0", k, bus.OutValid, bus.OutData); end
         step();
      end
   endtask

`ifdef ELASTIC_PIPE_SKID_BUF_EN
   task automatic test_skid();
      logic [7:0] exp_od [4];
      exp_od = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
      bus.OutReady = 1'b0; bus.InValid = 1'b1;
      bus.InData = 8'hB1; step();
      bus.InData = 8'hB2; step();
      bus.InData = 8'hB3; step();
      n_tests++; if (bus.InReady !== 1'b1 || bus.Occupancy !== 3'd3) begin n_fail++; $display("FAIL sk_full: got ir=%b occ=%0d expected ir=1 occ=3", bus.InReady, bus.Occupancy); end
      bus.InData = 8'hB4; step();
      bus.InValid = 1'b0;
      n_tests++; if (bus.Occupancy !== 3'd4) begin n_fail++; $display("FAIL sk_occ: got %0d expected 4", bus.Occupancy); end
      n_tests++; if (bus.InReady !== 1'b0) begin n_fail++; $display("FAIL sk_ir: got %b expected 0", bus.InReady); end
      step();
      n_tests++; if (bus.Occupancy !== 3'd4 || bus.InReady !== 1'b0) begin n_fail++; $display("FAIL sk_hold: got occ=%0d ir=%b expected occ=4 ir=0", bus.Occupancy, bus.InReady); end
      bus.OutReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (bus.OutValid !== 1'b1 || bus.OutData !== exp_od[k]) begin n_fail++; $display("FAIL sk_out[%0d]: got ov=%b od=%h expected ov=1 od=%h", k, bus.OutValid, bus.OutData, exp_od[k]); end
         step();
      end
      n_tests++; if (bus.InReady !== 1'b1 || bus.Occupancy !== 3'd0 || bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL sk_end: got ir=%b occ=%0d ov=%b expected ir=1 occ=0 ov=0", bus.InReady, bus.Occupancy, bus.OutValid); end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
`ifndef ELASTIC_PIPE_SKID_BUF_EN
      test_backpressure();
`endif
      test_bubble();
      test_flush();
`ifdef ELASTIC_PIPE_SKID_BUF_EN
      test_skid();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
